// File: rtl/led_fade_pkg.sv
// Shared types and helpers for the breathing LED duty sequencer.
package led_fade_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRampUp   = 3'd1,
        StHoldHigh = 3'd2,
        StRampDown = 3'd3,
        StHoldLow  = 3'd4
    } fade_state_e;

    // Largest duty code representable in duty_w bits.
    function automatic int unsigned duty_max(input int unsigned duty_w);
        return (32'd1 << duty_w) - 32'd1;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fade_step_timer.sv
// Step prescaler: counts 0..STEP_CYCLES-1 while running and flags the last count.
module fade_step_timer
    import led_fade_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CntW    = cnt_width(STEP_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_fade_sequencer.sv
// Breathing brightness generator: ramps duty up, holds, ramps down, holds, repeats.
module led_fade_sequencer
    import led_fade_pkg::*;
#(
    parameter int unsigned DUTY_W      = 4,
    parameter int unsigned STEP_CYCLES = 1_000_000,
    parameter int unsigned HOLD_STEPS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pause,
    output logic [DUTY_W-1:0] duty,
    output logic              step_tick,
    output logic              cycle_done,
    output logic [2:0]        state
);

    localparam logic [DUTY_W-1:0] DutyMax  = DUTY_W'(duty_max(DUTY_W));
    localparam int unsigned       HoldW    = cnt_width(HOLD_STEPS);
    localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD_STEPS - 1);

    fade_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              step_tick_q, step_tick_d;
    logic              cycle_done_q, cycle_done_d;

    logic timer_run;
    logic timer_clear;
    logic timer_tick;

    assign timer_run   = en && !pause && (state_q != StIdle);
    assign timer_clear = !en || (state_q == StIdle);

    fade_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (timer_run),
        .clear (timer_clear),
        .tick  (timer_tick)
    );

    // Priority: en low, then pause, then leaving IDLE, then the step tick.
    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        hold_d       = hold_q;
        step_tick_d  = 1'b0;
        cycle_done_d = 1'b0;

        if (!en) begin
            state_d = StIdle;
            duty_d  = '0;
            hold_d  = '0;
        end else if (pause) begin
            state_d = state_q;
        end else if (state_q == StIdle) begin
            state_d = StRampUp;
            duty_d  = '0;
            hold_d  = '0;
        end else if (timer_tick) begin
            step_tick_d = 1'b1;
            unique case (state_q)
                StRampUp: begin
                    if (duty_q >= DutyMax - DUTY_W'(1)) begin
                        duty_d  = DutyMax;
                        state_d = StHoldHigh;
                        hold_d  = '0;
                    end else begin
                        duty_d = duty_q + DUTY_W'(1);
                    end
                end
                StHoldHigh: begin
                    if (hold_q >= HoldLast) begin
                        state_d = StRampDown;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
                StRampDown: begin
                    if (duty_q <= DUTY_W'(1)) begin
                        duty_d  = '0;
                        state_d = StHoldLow;
                        hold_d  = '0;
                    end else begin
                        duty_d = duty_q - DUTY_W'(1);
                    end
                end
                StHoldLow: begin
                    if (hold_q >= HoldLast) begin
                        state_d      = StRampUp;
                        hold_d       = '0;
                        cycle_done_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
                default: begin
                    state_d     = StIdle;
                    duty_d      = '0;
                    hold_d      = '0;
                    step_tick_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            duty_q       <= '0;
            hold_q       <= '0;
            step_tick_q  <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            hold_q       <= hold_d;
            step_tick_q  <= step_tick_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign duty       = duty_q;
    assign step_tick  = step_tick_q;
    assign cycle_done = cycle_done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Bench: two sequencer instances (4/4/2 and 4/1/1) against a step-position reference model.
module tb_led_fade_sequencer;

    localparam int DMAX = 15;
    localparam int SC_A = 4;
    localparam int HS_A = 2;
    localparam int SC_B = 1;
    localparam int HS_B = 1;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pause;
    logic [3:0] duty_a, duty_b;
    logic       step_tick_a, step_tick_b;
    logic       cycle_done_a, cycle_done_b;
    logic [2:0] state_a, state_b;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    led_fade_sequencer #(
        .DUTY_W      (4),
        .STEP_CYCLES (SC_A),
        .HOLD_STEPS  (HS_A)
    ) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pause      (pause),
        .duty       (duty_a),
        .step_tick  (step_tick_a),
        .cycle_done (cycle_done_a),
        .state      (state_a)
    );

    led_fade_sequencer #(
        .DUTY_W      (4),
        .STEP_CYCLES (SC_B),
        .HOLD_STEPS  (HS_B)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pause      (pause),
        .duty       (duty_b),
        .step_tick  (step_tick_b),
        .cycle_done (cycle_done_b),
        .state      (state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: running flag, active cycles into current step, steps taken since enable.
    typedef struct packed {
        bit run;
        int c;
        int s;
        bit tick;
        bit done;
    } model_t;

    model_t ma = '0;
    model_t mb = '0;

    function automatic int period(input int hs);
        return 2 * DMAX + 2 * hs;
    endfunction

    function automatic model_t model_step(input model_t m, input bit e, input bit p,
                                          input int sc, input int hs);
        model_t n;
        n = m;
        n.tick = 0;
        n.done = 0;
        if (!e) begin
            n.run = 0;
            n.c   = 0;
            n.s   = 0;
        end else if (p) begin
            n.run = m.run;
        end else if (!m.run) begin
            n.run = 1;
            n.c   = 0;
            n.s   = 0;
        end else if (m.c + 1 == sc) begin
            n.c    = 0;
            n.s    = m.s + 1;
            n.tick = 1;
            n.done = ((n.s % period(hs)) == 0);
        end else begin
            n.c = m.c + 1;
        end
        return n;
    endfunction

    function automatic int exp_state(input model_t m, input int hs);
        int pos;
        if (!m.run) return 0;
        pos = m.s % period(hs);
        if (pos < DMAX) return 1;
        if (pos < DMAX + hs) return 2;
        if (pos < 2 * DMAX + hs) return 3;
        return 4;
    endfunction

    function automatic int exp_duty(input model_t m, input int hs);
        int pos;
        if (!m.run) return 0;
        pos = m.s % period(hs);
        if (pos < DMAX) return pos;
        if (pos < DMAX + hs) return DMAX;
        if (pos < 2 * DMAX + hs) return DMAX - (pos - DMAX - hs);
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int expv);
        checks++;
        if (act !== 32'(expv)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= model_step(ma, en, pause, SC_A, HS_A);
            mb <= model_step(mb, en, pause, SC_B, HS_B);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_duty", duty_a, exp_duty(ma, HS_A));
            check("a_state", state_a, exp_state(ma, HS_A));
            check("a_step_tick", step_tick_a, int'(ma.tick));
            check("a_cycle_done", cycle_done_a, int'(ma.done));
            check("b_duty", duty_b, exp_duty(mb, HS_B));
            check("b_state", state_b, exp_state(mb, HS_B));
            check("b_step_tick", step_tick_b, int'(mb.tick));
            check("b_cycle_done", cycle_done_b, int'(mb.done));
        end
    end

    initial begin
        int ticks;
        int resume_edges;
        bit found;

        rst_n = 1'b1;
        en    = 1'b0;
        pause = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_duty", duty_a, 0);
        check("rst_state", state_a, 0);
        check("rst_step_tick", step_tick_a, 0);
        check("rst_cycle_done", cycle_done_a, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1;
        repeat (3) @(negedge clk);

        // Full breath period, en sampled at edge 0.
        en = 1'b1;
        @(posedge clk);
        ticks = 0;
        for (int e = 1; e <= 137; e++) begin
            @(posedge clk);
            #1;
            if (e <= 136) ticks += int'(step_tick_a);
            if (e == 3) check("s2_duty_e3", duty_a, 0);
            if (e == 4) check("s2_duty_e4", duty_a, 1);
            if (e == 60) begin
                check("s2_duty_e60", duty_a, 15);
                check("s2_state_e60", state_a, 2);
            end
            if (e == 67) check("s2_state_e67", state_a, 2);
            if (e == 68) check("s2_state_e68", state_a, 3);
            if (e == 128) begin
                check("s2_duty_e128", duty_a, 0);
                check("s2_state_e128", state_a, 4);
            end
            if (e == 136) begin
                check("s2_state_e136", state_a, 1);
                check("s2_done_e136", cycle_done_a, 1);
            end
            if (e == 137) check("s2_done_e137", cycle_done_a, 0);
            if (e <= 32) check("s5_tick_const", step_tick_b, 1);
            if (e == 15) begin
                check("s5_duty_e15", duty_b, 15);
                check("s5_state_e15", state_b, 2);
            end
            if (e == 16) begin
                check("s5_state_e16", state_b, 3);
                check("s5_duty_e16", duty_b, 15);
            end
            if (e == 31) begin
                check("s5_duty_e31", duty_b, 0);
                check("s5_state_e31", state_b, 4);
            end
            if (e == 32) begin
                check("s5_state_e32", state_b, 1);
                check("s5_done_e32", cycle_done_b, 1);
            end
            if (e == 64) check("s5_done_e64", cycle_done_b, 1);
        end
        check("s2_tick_count", ticks, 34);

        // Pause at duty 5, right after the step that produced it.
        found = 0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (exp_state(ma, HS_A) == 1 && exp_duty(ma, HS_A) == 5 && ma.c == 0) found = 1;
        end
        check("s3_reach_duty5", int'(found), 1);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("s3_pause_duty", duty_a, 5);
            check("s3_pause_tick", step_tick_a, 0);
        end
        pause = 1'b0;
        resume_edges = 0;
        for (int k = 1; k <= 8 && resume_edges == 0; k++) begin
            @(posedge clk);
            #1;
            if (duty_a != 4'd5) resume_edges = k;
        end
        check("s3_resume_edges", resume_edges, 4);
        check("s3_duty_after", duty_a, 6);

        // Drop en in HOLD_HIGH on a tick cycle.
        found = 0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (exp_state(ma, HS_A) == 2 && ma.c == SC_A - 1) found = 1;
        end
        check("s4_reach_hold_tick", int'(found), 1);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("s4_state_idle", state_a, 0);
        check("s4_duty_zero", duty_a, 0);
        check("s4_no_done", cycle_done_a, 0);
        check("s4_no_tick", step_tick_a, 0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("s4_reentry_state", state_a, 1);
        check("s4_reentry_duty", duty_a, 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) check("s4_duty_k3", duty_a, 0);
            if (k == 4) check("s4_duty_k4", duty_a, 1);
        end

        // Asynchronous reset between edges, mid-ramp.
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s1_async_duty_a", duty_a, 0);
        check("s1_async_state_a", state_a, 0);
        check("s1_async_tick_b", step_tick_b, 0);
        check("s1_async_duty_b", duty_b, 0);
        check("s1_async_done_a", cycle_done_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random en/pause activity.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (en) begin
                if ($urandom_range(199) == 0) en = 1'b0;
            end else if ($urandom_range(9) == 0) begin
                en = 1'b1;
            end
            if ($urandom_range(29) == 0) pause = ~pause;
        end

        @(negedge clk);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
